wb_sequencer: RTL and testbench
===============================

// Module: wb_sequencer
// PURPOSE
//   Write-back controller for the register-destination mux and the register-file write port.
//   Accepts one write-back op per instruction from the main control FSM.
//   Sequences one or two register writes: drives the mux selector, the write-back data source and reg_write.
//   Handles POP, which waits for memory, then writes rt and then $sp (reg 29).
// PARAMETERS
//   MEM_LAT   2   cycles waited before the POP memory write-back (0 = no wait)
//   CNT_W     2   wait-counter width; must satisfy 2**CNT_W > MEM_LAT
// PORTS
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-low reset
//   start        in   1  one-cycle request; sampled only when busy==0
//   wb_op        in   3  op code, captured with start (codes in package)
//   flush        in   1  synchronous abort of the op in flight
//   reg_dst_sel  out  3  regDst mux selector: 000 rt, 001 rd, 010 const 29, 011 data_3, 100 const 31
//   wb_src       out  2  write-data source: 0 ALU, 1 MEM, 2 PC+4, 3 SP_ADJ
//   reg_write    out  1  register-file write enable
//   busy         out  1  op in flight; start is ignored while high
//   done         out  1  one-cycle pulse when the op completes
// BEHAVIOUR
//   Reset value of every output is 0: reg_dst_sel=000, wb_src=0, reg_write=0, busy=0, done=0.
//   Reset asserted mid-op: FSM returns to IDLE immediately and the wait counter clears.
//   States: IDLE, WAIT, WR1, WR2. Outputs decode from the state only (Moore); flush gates them as below.
//   Op codes and sequences; "X" is the cycle after start:
//     NONE(0)  X: done=1, no write.
//     RT(1)    WR1 in X: sel 000, src ALU.
//     RD(2)    WR1 in X: sel 001, src ALU.
//     SP(3)    WR1 in X: sel 010, src SP_ADJ.
//     ALT(4)   WR1 in X: sel 011, src ALU.
//     LINK(5)  WR1 in X: sel 100, src PC+4.
//     POP(6)   WAIT for MEM_LAT cycles, then WR1 (sel 000, src MEM), then WR2 (sel 010, src SP_ADJ).
//              If MEM_LAT==0, WAIT is skipped.
//     7        reserved; treated as NONE.
//   reg_write=1 for exactly one cycle in each WR state.
//   done=1 in the last state of the op (WR1, or WR2 for POP), then IDLE on the next edge.
//   busy=1 in WAIT, WR1 and WR2; busy=0 in IDLE, including the NONE done cycle.
//   Back-to-back ops: start is accepted in the cycle after done (FSM is in IDLE again).
//   Wait counter: loads MEM_LAT-1 on entry to WAIT and decrements each cycle.
//     WAIT->WR1 when the counter is 0. No wrap-around is possible.
//   start while busy: ignored; wb_op is not re-captured.
//   flush: forces reg_write=0 and done=0 in the same cycle; FSM -> IDLE on the next edge.
//     Flush during WR2 of POP suppresses the $sp write; the rt write already made stands.
//   flush and start together in IDLE: flush wins, start is dropped.
//   In IDLE, reg_dst_sel=000 and wb_src=0.
// STRUCTURE
//   Package wb_pkg holds:
//     - wb_op codes (WB_NONE..WB_POP);
//     - selector constants SEL_RT=3'b000, SEL_RD=3'b001, SEL_SP=3'b010, SEL_ALT=3'b011, SEL_RA=3'b100;
//     - wb_src codes;
//     - state encoding.
//   Single module, no sub-module. The wait counter is inline.
// TESTING
//   1. Reset low mid-POP (in WAIT) -> all outputs 0 at once; after release a LINK op runs normally.
//   2. start with wb_op=RD -> next cycle sel=001, src=0, reg_write=1, done=1, busy=1; then sel=000, busy=0.
//   3. POP with MEM_LAT=2 -> 2 WAIT cycles (reg_write=0, busy=1).
//      Then WR1 (sel 000, src 1, reg_write=1), then WR2 (sel 010, src 3, reg_write=1, done=1).
//   4. POP with MEM_LAT=0 -> WR1 in X, WR2 in X+1; start pulsed during WR1 is ignored.
//   5. flush during WR2 of POP -> reg_write=0, done=0 that cycle; IDLE next; exactly one reg write seen.
//   6. NONE then LINK back-to-back -> done in X with no write; LINK accepted at X+1.
//      Then sel=100, src=2, reg_write=1 at X+2.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back sequencer: op codes, mux selector
// constants, write-data sources, FSM states and the WR1 decode helpers.
package wb_pkg;

  typedef enum logic [2:0] {
    WB_NONE = 3'd0,
    WB_RT   = 3'd1,
    WB_RD   = 3'd2,
    WB_SP   = 3'd3,
    WB_ALT  = 3'd4,
    WB_LINK = 3'd5,
    WB_POP  = 3'd6,
    WB_RSVD = 3'd7
  } wb_op_e;

  localparam logic [2:0] SEL_RT  = 3'b000;
  localparam logic [2:0] SEL_RD  = 3'b001;
  localparam logic [2:0] SEL_SP  = 3'b010;
  localparam logic [2:0] SEL_ALT = 3'b011;
  localparam logic [2:0] SEL_RA  = 3'b100;

  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_MEM    = 2'd1,
    SRC_PC4    = 2'd2,
    SRC_SP_ADJ = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_WR1  = 2'd2,
    ST_WR2  = 2'd3
  } wb_state_e;

  // Destination selector used in WR1 for each op (POP writes rt first).
  function automatic logic [2:0] wr1_sel(wb_op_e op);
    case (op)
      WB_RD:   return SEL_RD;
      WB_SP:   return SEL_SP;
      WB_ALT:  return SEL_ALT;
      WB_LINK: return SEL_RA;
      default: return SEL_RT;
    endcase
  endfunction

  function automatic wb_src_e wr1_src(wb_op_e op);
    case (op)
      WB_SP:   return SRC_SP_ADJ;
      WB_LINK: return SRC_PC4;
      WB_POP:  return SRC_MEM;
      default: return SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Request/response bundle between the main control FSM (master) and the
// write-back sequencer (slave).
interface wb_sequencer_if;
  logic       start;
  logic [2:0] wb_op;
  logic       flush;
  logic [2:0] reg_dst_sel;
  logic [1:0] wb_src;
  logic       reg_write;
  logic       busy;
  logic       done;

  modport master (
    output start, wb_op, flush,
    input  reg_dst_sel, wb_src, reg_write, busy, done
  );

  modport slave (
    input  start, wb_op, flush,
    output reg_dst_sel, wb_src, reg_write, busy, done
  );
endinterface

// File: rtl/wb_sequencer.sv
// Write-back sequencer: issues one or two register-file writes per op
// (two for POP, after an optional memory wait) with Moore-decoded outputs.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  wb_sequencer_if.slave bus
);

  localparam int               LOAD_I   = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_I);

  wb_state_e        state_q, state_d;
  wb_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= WB_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            // Reserved code behaves exactly like NONE.
            op_d = (bus.wb_op == WB_RSVD) ? WB_NONE : wb_op_e'(bus.wb_op);
            if (bus.wb_op == WB_POP && MEM_LAT > 0) begin
              state_d = ST_WAIT;
              cnt_d   = CNT_LOAD;
            end else begin
              state_d = ST_WR1;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_d = ST_WR1;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_WR1:  state_d = (op_q == WB_POP) ? ST_WR2 : ST_IDLE;
        ST_WR2:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NONE also passes through WR1 to produce its done pulse, but without
  // writing and without raising busy.
  always_comb begin
    bus.reg_dst_sel = SEL_RT;
    bus.wb_src      = SRC_ALU;
    bus.reg_write   = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (state_q)
      ST_WAIT: bus.busy = 1'b1;
      ST_WR1: begin
        bus.reg_dst_sel = wr1_sel(op_q);
        bus.wb_src      = wr1_src(op_q);
        bus.reg_write   = (op_q != WB_NONE);
        bus.busy        = (op_q != WB_NONE);
        bus.done        = (op_q != WB_POP);
      end
      ST_WR2: begin
        bus.reg_dst_sel = SEL_SP;
        bus.wb_src      = SRC_SP_ADJ;
        bus.reg_write   = 1'b1;
        bus.busy        = 1'b1;
        bus.done        = 1'b1;
      end
      default: ;
    endcase
    if (bus.flush) begin
      bus.reg_write = 1'b0;
      bus.done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: a vector table for single-write ops plus
// hand-written POP, reset, flush and back-to-back sequences.
module tb_wb_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_sequencer_if a_if ();
  wb_sequencer_if b_if ();

  wb_sequencer #(.MEM_LAT(2), .CNT_W(2)) dut_a (.clk(clk), .reset(rst_n), .bus(a_if));
  wb_sequencer #(.MEM_LAT(0), .CNT_W(1)) dut_b (.clk(clk), .reset(rst_n), .bus(b_if));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_a(input string tag, input int sel, input int src, input int wr,
                       input int bsy, input int dn);
    chk({tag, ".sel"},  int'(a_if.reg_dst_sel), sel);
    chk({tag, ".src"},  int'(a_if.wb_src), src);
    chk({tag, ".wr"},   int'(a_if.reg_write), wr);
    chk({tag, ".busy"}, int'(a_if.busy), bsy);
    chk({tag, ".done"}, int'(a_if.done), dn);
    $display("[%0t] A %s sel=%0d src=%0d wr=%0d busy=%0d done=%0d", $time, tag,
             a_if.reg_dst_sel, a_if.wb_src, a_if.reg_write, a_if.busy, a_if.done);
  endtask

  task automatic chk_b(input string tag, input int sel, input int src, input int wr,
                       input int bsy, input int dn);
    chk({tag, ".sel"},  int'(b_if.reg_dst_sel), sel);
    chk({tag, ".src"},  int'(b_if.wb_src), src);
    chk({tag, ".wr"},   int'(b_if.reg_write), wr);
    chk({tag, ".busy"}, int'(b_if.busy), bsy);
    chk({tag, ".done"}, int'(b_if.done), dn);
    $display("[%0t] B %s sel=%0d src=%0d wr=%0d busy=%0d done=%0d", $time, tag,
             b_if.reg_dst_sel, b_if.wb_src, b_if.reg_write, b_if.busy, b_if.done);
  endtask

  // Raise start at the falling edge, leave it high across one rising edge.
  task automatic start_a(input logic [2:0] op);
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.wb_op = op;
    @(posedge clk);
    #1 a_if.start = 1'b0;
  endtask

  task automatic start_b(input logic [2:0] op);
    @(negedge clk);
    b_if.start = 1'b1;
    b_if.wb_op = op;
    @(posedge clk);
    #1 b_if.start = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] sel;
    logic [1:0] src;
    logic       wr;
    logic       bsy;
  } vec_t;

  vec_t vecs[7];
  int   b_writes;

  initial begin
    vecs[0] = '{op: 3'd1, sel: 3'b000, src: 2'd0, wr: 1'b1, bsy: 1'b1};
    vecs[1] = '{op: 3'd2, sel: 3'b001, src: 2'd0, wr: 1'b1, bsy: 1'b1};
    vecs[2] = '{op: 3'd3, sel: 3'b010, src: 2'd3, wr: 1'b1, bsy: 1'b1};
    vecs[3] = '{op: 3'd4, sel: 3'b011, src: 2'd0, wr: 1'b1, bsy: 1'b1};
    vecs[4] = '{op: 3'd5, sel: 3'b100, src: 2'd2, wr: 1'b1, bsy: 1'b1};
    vecs[5] = '{op: 3'd0, sel: 3'b000, src: 2'd0, wr: 1'b0, bsy: 1'b0};
    vecs[6] = '{op: 3'd7, sel: 3'b000, src: 2'd0, wr: 1'b0, bsy: 1'b0};

    a_if.start = 1'b0; a_if.wb_op = 3'd0; a_if.flush = 1'b0;
    b_if.start = 1'b0; b_if.wb_op = 3'd0; b_if.flush = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 chk_a("reset", 0, 0, 0, 0, 0);
    chk_b("reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-POP while waiting for memory, then a LINK runs normally
    start_a(3'd6);
    chk_a("pop_wait_pre_rst", 0, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk_a("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    start_a(3'd5);
    chk_a("link_after_rst", 4, 2, 1, 1, 1);
    step();
    chk_a("link_after_rst_idle", 0, 0, 0, 0, 0);

    // Single-write ops and NONE/reserved from the table
    for (int i = 0; i < 7; i++) begin
      start_a(vecs[i].op);
      chk_a($sformatf("vec%0d_op%0d", i, vecs[i].op), int'(vecs[i].sel), int'(vecs[i].src),
            int'(vecs[i].wr), int'(vecs[i].bsy), 1);
      step();
      chk_a($sformatf("vec%0d_idle", i), 0, 0, 0, 0, 0);
    end

    // POP with a two-cycle memory wait
    start_a(3'd6);
    chk_a("pop_wait1", 0, 0, 0, 1, 0);
    step();
    chk_a("pop_wait2", 0, 0, 0, 1, 0);
    step();
    chk_a("pop_wr1", 0, 1, 1, 1, 0);
    step();
    chk_a("pop_wr2", 2, 3, 1, 1, 1);
    step();
    chk_a("pop_idle", 0, 0, 0, 0, 0);

    // POP without a wait; a start during WR1 must not be captured
    start_b(3'd6);
    chk_b("pop0_wr1", 0, 1, 1, 1, 0);
    b_if.start = 1'b1; b_if.wb_op = 3'd2;
    step();
    b_if.start = 1'b0;
    chk_b("pop0_wr2", 2, 3, 1, 1, 1);
    step();
    chk_b("pop0_idle_no_rd", 0, 0, 0, 0, 0);

    // Flush during WR2 suppresses the $sp write only
    b_writes = 0;
    start_b(3'd6);
    chk_b("flush_wr1", 0, 1, 1, 1, 0);
    if (b_if.reg_write) b_writes++;
    step();
    b_if.flush = 1'b1;
    #1 chk_b("flush_wr2", 2, 3, 0, 1, 0);
    if (b_if.reg_write) b_writes++;
    step();
    b_if.flush = 1'b0;
    chk_b("flush_idle", 0, 0, 0, 0, 0);
    if (b_if.reg_write) b_writes++;
    chk("flush_write_count", b_writes, 1);

    // Flush and start together in IDLE: start dropped
    @(negedge clk);
    a_if.start = 1'b1; a_if.wb_op = 3'd1; a_if.flush = 1'b1;
    step();
    a_if.start = 1'b0; a_if.flush = 1'b0;
    chk_a("flush_start_dropped", 0, 0, 0, 0, 0);

    // NONE then LINK back-to-back
    start_a(3'd0);
    chk_a("b2b_none_x", 0, 0, 0, 0, 1);
    step();
    chk_a("b2b_x1_idle", 0, 0, 0, 0, 0);
    a_if.start = 1'b1; a_if.wb_op = 3'd5;
    step();
    a_if.start = 1'b0;
    chk_a("b2b_link_x2", 4, 2, 1, 1, 1);
    step();
    chk_a("b2b_idle", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
